// File: rtl/convolution_unit.sv
// 3x3 multiply-accumulate window engine: unsigned pixels times signed coefficients,
// three-stage pipeline ending in a saturated signed result register.
module convolution_unit #(
    parameter int PIXEL_W = 8,
    parameter int COEFF_W = 8,
    parameter int OUT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9*PIXEL_W-1:0]      image,
    input  logic [9*COEFF_W-1:0]      kernel,
    output logic signed [OUT_W-1:0]   result
);

    localparam int PROD_W = PIXEL_W + 1 + COEFF_W;
    localparam int SUM_W  = PROD_W + 4;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(1 << (OUT_W - 1)));

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] s);
        if (s > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        else
            return s[OUT_W-1:0];
    endfunction

    logic        [9*PIXEL_W-1:0] r_img_p0;
    logic        [9*COEFF_W-1:0] r_ker_p0;
    logic signed [PROD_W-1:0]    w_prod   [9];
    logic signed [PROD_W-1:0]    r_prod_p1 [9];
    logic signed [SUM_W-1:0]     w_sum;
    logic signed [OUT_W-1:0]     r_result_p2;

    // Stage p0: capture the window and kernel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_img_p0 <= '0;
            r_ker_p0 <= '0;
        end else begin
            r_img_p0 <= image;
            r_ker_p0 <= kernel;
        end
    end

    // Index 0 lives in the top byte, so position i is read from slot 8-i
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_prod[i] = $signed({1'b0, r_img_p0[(8-i)*PIXEL_W +: PIXEL_W]})
                      * $signed(r_ker_p0[(8-i)*COEFF_W +: COEFF_W]);
        end
    end

    // Stage p1: nine registered products
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) r_prod_p1[i] <= '0;
        end else begin
            for (int i = 0; i < 9; i++) r_prod_p1[i] <= w_prod[i];
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 9; i++) begin
            w_sum = w_sum + SUM_W'(r_prod_p1[i]);
        end
    end

    // Stage p2: saturated sum drives the output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_result_p2 <= '0;
        else
            r_result_p2 <= sat_out(w_sum);
    end

    assign result = r_result_p2;

endmodule

// File: tb/tb_convolution_unit.sv
// Directed bench for convolution_unit: latency, saturation, sign, throughput and async reset.
module tb_convolution_unit;

    logic               clk;
    logic               rst;
    logic [71:0]        image;
    logic [71:0]        kernel;
    logic signed [15:0] result;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [71:0] IMG_BASE = 72'h5A55829B3A84A2CF73;
    localparam logic [71:0] KER_BASE = 72'h0100FF0100FF0100FF;
    localparam logic [71:0] IMG_FF   = 72'hFFFFFFFFFFFFFFFFFF;
    localparam logic [71:0] KER_7F   = 72'h7F7F7F7F7F7F7F7F7F;
    localparam logic [71:0] KER_80   = 72'h808080808080808080;
    localparam logic [71:0] KER_ID   = 72'h000000000100000000;
    localparam logic [71:0] KER_NID  = 72'h00000000FF00000000;
    localparam logic [71:0] KER_ZERO = 72'h000000000000000000;

    convolution_unit dut (
        .clk    (clk),
        .rst    (rst),
        .image  (image),
        .kernel (kernel),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [15:0] exp);
        n_cmp++;
        assert (result === exp) else begin
            n_err++;
            $error("FAIL %s: result=%0d required=%0d", tag, result, exp);
        end
    endtask

    initial begin
        rst    = 1'b0;
        image  = IMG_BASE;
        kernel = KER_BASE;
        #2;
        check("reset_async", 16'sd0);
        tick();
        tick();
        check("reset_hold_inputs_ignored", 16'sd0);

        // Release reset away from the edge; first edge samples the baseline.
        #2 rst = 1'b1;
        tick(); check("base_edge1", 16'sd0);
        tick(); check("base_edge2", 16'sd0);
        tick(); check("base_edge3", 16'sd30);
        tick(); check("base_stable", 16'sd30);

        image = IMG_FF; kernel = KER_7F;
        tick(); check("possat_edge1_old", 16'sd30);
        tick(); check("possat_edge2_old", 16'sd30);
        tick(); check("pos_saturation", 16'sh7FFF);

        kernel = KER_80;
        tick(); tick(); tick();
        check("neg_saturation", -16'sd32768);

        image = IMG_BASE; kernel = KER_ID;
        tick(); tick(); tick();
        check("identity_k4", 16'sd58);

        kernel = KER_NID;
        tick(); tick(); tick();
        check("identity_neg_k4", -16'sd58);
        tick(); check("identity_neg_stable", -16'sd58);

        // Three different windows on consecutive edges.
        image = IMG_BASE; kernel = KER_BASE;
        tick(); kernel = KER_ID;
        check("thru_a_old", -16'sd58);
        tick(); kernel = KER_ZERO;
        check("thru_b_old", -16'sd58);
        tick(); check("thru_base", 16'sd30);
        tick(); check("thru_identity", 16'sd58);
        tick(); check("thru_zero", 16'sd0);

        kernel = KER_BASE;
        tick(); tick(); tick();
        check("midrst_pre", 16'sd30);

        // Switch inputs and drop reset while the new window is in flight.
        kernel = KER_NID;
        tick();
        #2 rst = 1'b0;
        #1 check("midrst_async_clear", 16'sd0);
        kernel = KER_ID;
        tick(); check("midrst_held", 16'sd0);
        #2 rst = 1'b1;
        tick(); check("midrst_rel_edge1", 16'sd0);
        tick(); check("midrst_rel_edge2", 16'sd0);
        tick(); check("midrst_rel_edge3", 16'sd58);
        tick(); check("midrst_rel_stable", 16'sd58);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/convolution_unit.md
Name: convolution_unit

Overview:
Single 3x3 multiply-accumulate convolution (cross-correlation) engine. Takes one 3x3 unsigned 8-bit pixel window and one 3x3 signed 8-bit kernel per clock. Produces one saturated signed 16-bit result per clock after a fixed 3-cycle pipeline. Sits behind the window/line-buffer logic and feeds the activation/pooling stage.

Parameters:
PIXEL_W, 8, pixel width (unsigned); port widths are fixed at the defaults
COEFF_W, 8, kernel coefficient width (signed two's complement)
OUT_W, 16, result width (signed two's complement, saturated)

Ports:
clk  input  1  system clock, all registers rising-edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
image  input  72  nine pixels, row-major; p0=image[71:64] (row0,col0) ... p8=image[7:0] (row2,col2)
kernel  input  72  nine coefficients, same packing; k0=kernel[71:64] ... k8=kernel[7:0]
result  output  16  signed sum of p_i*k_i, saturated to 16 bits

Behaviour:
- Function: result = SAT16( sum over i=0..8 of unsigned(p_i) * signed(k_i) ). No kernel flip: p_i pairs with k_i at the same packed position.
- Arithmetic: p_i is zero-extended to 9 bits signed, then multiplied by k_i giving a 17-bit signed product. The sum is taken in at least 21-bit signed precision, with no intermediate overflow. Range is -293760..+291465.
- Saturation: sum > 32767 -> 32767 (0x7FFF). Sum < -32768 -> -32768 (0x8000). Otherwise the exact value.
- Pipeline, one input accepted every cycle with no stall and no handshake:
  - Stage 1 (edge 1): register image and kernel.
  - Stage 2 (edge 2): register the nine products.
  - Stage 3 (edge 3): register the adder-tree sum after saturation, driving result.
- Latency: inputs sampled at rising edge N appear on result after edge N+2, i.e. visible following the 3rd edge. Throughput is 1 result/cycle.
- result is a registered output with no combinational path from the inputs.
- Reset, while rst=0:
  - All pipeline registers (input, product, output) clear to 0 immediately, without waiting for a clock edge.
  - result = 0.
  - Inputs are ignored.
- Reset release: the first edge with rst=1 samples the inputs. result stays 0 (zero pipeline contents) until the first real result appears after the 3rd edge.
- Reset mid-operation: in-flight data is discarded and none of it ever appears on result.
- Inputs held constant: result is stable and is recomputed identically every cycle.

Test Plan:
1. Baseline vector, async reset pulse then rst=1:
   - image = 5A 55 82 9B 3A 84 A2 CF 73 (p0..p8), kernel = 01 00 FF 01 00 FF 01 00 FF.
   - Required: result = 0 for the first two edges, then 30 (0x001E) after the 3rd edge, and it stays 30.
2. Positive saturation: all pixels 0xFF, all coefficients 0x7F (sum 291465) -> result = 32767 (0x7FFF).
3. Negative saturation: all pixels 0xFF, all coefficients 0x80 (sum -293760) -> result = -32768 (0x8000).
4. Identity and sign:
   - kernel with only k4 = 0x01, the baseline image -> result = 58.
   - kernel with only k4 = 0xFF -> result = -58 (0xFFC6).
5. Throughput: apply three different windows on consecutive edges (baseline, identity, all-zero kernel) -> results 30, 58, 0 on three consecutive cycles, each 3 edges after its input.
6. Async reset mid-stream:
   - Drop rst low between edges while result = 30 -> result goes to 0 before the next edge.
   - Release rst -> result stays 0 for two edges, then shows the current input's value.
